// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: operation encoding and flag bit positions.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'd0,
    ALU_OR    = 4'd1,
    ALU_ADD   = 4'd2,
    ALU_XOR   = 4'd3,
    ALU_SLL   = 4'd4,
    ALU_SRL   = 4'd5,
    ALU_SUB   = 4'd6,
    ALU_SLT   = 4'd7,
    ALU_NOR   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_SLTU  = 4'd10,
    ALU_PASSB = 4'd11
  } alu_op_t;

  localparam int unsigned FLAG_N  = 3;
  localparam int unsigned FLAG_V  = 2;
  localparam int unsigned FLAG_C  = 1;
  localparam int unsigned FLAG_ZF = 0;
  localparam int unsigned FLAG_W  = 4;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU datapath: result for every op select, plus {N,V,C,Zf} when ALU_FLAGS_EN is defined.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned n = 32
) (
  input  logic [n-1:0]      A,
  input  logic [n-1:0]      B,
  input  logic [3:0]        S,
`ifdef ALU_FLAGS_EN
  output logic [FLAG_W-1:0] flags_c,
`endif
  output logic [n-1:0]      z_c
);

  localparam int unsigned SH = $clog2(n);

  alu_op_t       op;
  logic [SH-1:0] shamt;

  assign op    = alu_op_t'(S);
  // Upper bits of B are ignored, so shift amounts wrap modulo 2^SH.
  assign shamt = B[SH-1:0];

  always_comb begin
    z_c = '0;
    case (op)
      ALU_AND:   z_c = A & B;
      ALU_OR:    z_c = A | B;
      ALU_ADD:   z_c = A + B;
      ALU_XOR:   z_c = A ^ B;
      ALU_SLL:   z_c = A << shamt;
      ALU_SRL:   z_c = A >> shamt;
      ALU_SUB:   z_c = A - B;
      ALU_SLT:   z_c = n'($signed(A) < $signed(B));
      ALU_NOR:   z_c = ~(A | B);
      ALU_SRA:   z_c = n'($signed(A) >>> shamt);
      ALU_SLTU:  z_c = n'(A < B);
      ALU_PASSB: z_c = B;
      default:   z_c = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic [n:0] sum_w;
  logic [n:0] diff_w;

  assign sum_w  = {1'b0, A} + {1'b0, B};
  assign diff_w = {1'b0, A} - {1'b0, B};

  // C is NOT borrow for SUB so that A >= B (unsigned) reads as C=1.
  always_comb begin
    flags_c          = '0;
    flags_c[FLAG_ZF] = (z_c == '0);
    flags_c[FLAG_N]  = z_c[n-1];
    case (op)
      ALU_ADD: begin
        flags_c[FLAG_C] = sum_w[n];
        flags_c[FLAG_V] = (A[n-1] == B[n-1]) && (sum_w[n-1] != A[n-1]);
      end
      ALU_SUB: begin
        flags_c[FLAG_C] = ~diff_w[n];
        flags_c[FLAG_V] = (A[n-1] != B[n-1]) && (diff_w[n-1] != A[n-1]);
      end
      default: ;
    endcase
  end
`endif

endmodule

// File: rtl/alu_core.sv
// Execute-stage ALU with a one-cycle registered result; the flags port exists only when ALU_FLAGS_EN is defined.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned n = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [n-1:0]      A,
  input  logic [n-1:0]      B,
  input  logic [3:0]        S,
`ifdef ALU_FLAGS_EN
  output logic [FLAG_W-1:0] flags,
`endif
  output logic [n-1:0]      Z
);

  if (n < 8) begin : g_width_check
    $error("alu_core: n must be at least 8");
  end

  logic [n-1:0] z_c;

`ifdef ALU_FLAGS_EN
  logic [FLAG_W-1:0] flags_c;

  alu_comb #(.n(n)) u_comb (
    .A       (A),
    .B       (B),
    .S       (S),
    .flags_c (flags_c),
    .z_c     (z_c)
  );

  always_ff @(posedge clk) begin
    if (rst) flags <= '0;
    else     flags <= flags_c;
  end
`else
  alu_comb #(.n(n)) u_comb (
    .A   (A),
    .B   (B),
    .S   (S),
    .z_c (z_c)
  );
`endif

  // Reset takes priority over the computed result.
  always_ff @(posedge clk) begin
    if (rst) Z <= '0;
    else     Z <= z_c;
  end

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector and sweep bench for alu_core at n = 32; flags are checked when ALU_FLAGS_EN is defined.
module tb_alu_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A, B;
  logic [3:0]  S;
  logic [31:0] Z;
`ifdef ALU_FLAGS_EN
  logic [3:0]  flags;
`endif

  int tests = 0;
  int fails = 0;

  alu_core #(.n(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .S     (S),
`ifdef ALU_FLAGS_EN
    .flags (flags),
`endif
    .Z     (Z)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  s;
    logic [31:0] z;
    logic [3:0]  f;   // {N, V, C, Zf}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [31:0] a, logic [31:0] b,
                              logic [3:0] s, logic [31:0] z, logic [3:0] f);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.s = s; v.z = z; v.f = f;
    return v;
  endfunction

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check4(string name, logic [3:0] act, logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive inputs just after an edge, then sample 1 time unit after the capturing edge.
  task automatic apply(logic [31:0] a, logic [31:0] b, logic [3:0] s);
    A = a; B = b; S = s;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_z(logic [31:0] a, logic [31:0] b, logic [3:0] s);
    logic [31:0] r;
    int unsigned k;
    k = b & 32'd31;
    r = '0;
    case (s)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a ^ b;
      4'd4:  r = a << k;
      4'd5:  r = a >> k;
      4'd6:  r = a - b;
      4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  r = ~(a | b);
      4'd9:  begin r = a; for (int i = 0; i < int'(k); i++) r = {r[31], r[31:1]}; end
      4'd10: r = (a < b) ? 32'd1 : 32'd0;
      4'd11: r = b;
      default: r = '0;
    endcase
    return r;
  endfunction

  initial begin
    vecs.push_back(mk("and",       32'hF0F0F0F0, 32'hFF00FF00, 4'd0,  32'hF000F000, 4'b1000));
    vecs.push_back(mk("or",        32'hF0F0F0F0, 32'hFF00FF00, 4'd1,  32'hFFF0FFF0, 4'b1000));
    vecs.push_back(mk("xor",       32'hF0F0F0F0, 32'hFF00FF00, 4'd3,  32'h0FF00FF0, 4'b0000));
    vecs.push_back(mk("nor",       32'hF0F0F0F0, 32'hFF00FF00, 4'd8,  32'h000F000F, 4'b0000));
    vecs.push_back(mk("add_carry", 32'hFFFFFFFF, 32'h00000001, 4'd2,  32'h00000000, 4'b0011));
    vecs.push_back(mk("add_ovf",   32'h7FFFFFFF, 32'h00000001, 4'd2,  32'h80000000, 4'b1100));
    vecs.push_back(mk("sub_neg",   32'h00000003, 32'h00000005, 4'd6,  32'hFFFFFFFE, 4'b1000));
    vecs.push_back(mk("sub_eq",    32'h00000009, 32'h00000009, 4'd6,  32'h00000000, 4'b0011));
    vecs.push_back(mk("sub_ovf",   32'h80000000, 32'h00000001, 4'd6,  32'h7FFFFFFF, 4'b0110));
    vecs.push_back(mk("slt",       32'hFFFFFFFF, 32'h00000001, 4'd7,  32'h00000001, 4'b0000));
    vecs.push_back(mk("sltu",      32'hFFFFFFFF, 32'h00000001, 4'd10, 32'h00000000, 4'b0001));
    vecs.push_back(mk("slt_eq",    32'h00000007, 32'h00000007, 4'd7,  32'h00000000, 4'b0001));
    vecs.push_back(mk("sltu_eq",   32'h00000007, 32'h00000007, 4'd10, 32'h00000000, 4'b0001));
    vecs.push_back(mk("sll_wrap",  32'h80000001, 32'd33,       4'd4,  32'h00000002, 4'b0000));
    vecs.push_back(mk("srl_wrap",  32'h80000001, 32'd33,       4'd5,  32'h40000000, 4'b0000));
    vecs.push_back(mk("sra_wrap",  32'h80000001, 32'd33,       4'd9,  32'hC0000000, 4'b1000));
    vecs.push_back(mk("sra_31",    32'h80000000, 32'd31,       4'd9,  32'hFFFFFFFF, 4'b1000));
    vecs.push_back(mk("passb",     32'h00000001, 32'hDEADBEEF, 4'd11, 32'hDEADBEEF, 4'b1000));
    vecs.push_back(mk("rsv12",     32'hFFFFFFFF, 32'hFFFFFFFF, 4'd12, 32'h00000000, 4'b0001));
    vecs.push_back(mk("rsv13",     32'hFFFFFFFF, 32'hFFFFFFFF, 4'd13, 32'h00000000, 4'b0001));
    vecs.push_back(mk("rsv14",     32'hFFFFFFFF, 32'hFFFFFFFF, 4'd14, 32'h00000000, 4'b0001));
    vecs.push_back(mk("rsv15",     32'hFFFFFFFF, 32'hFFFFFFFF, 4'd15, 32'h00000000, 4'b0001));

    // Reset captures zero despite a live ADD on the inputs, then the ADD lands one edge after release.
    rst = 1'b1;
    A = 32'd5; B = 32'd3; S = 4'd2;
    @(posedge clk);
    #1;
    check32("reset_z", Z, 32'h0);
`ifdef ALU_FLAGS_EN
    check4("reset_flags", flags, 4'b0000);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
    check32("post_reset_add", Z, 32'd8);

    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].s);
      check32(vecs[i].name, Z, vecs[i].z);
`ifdef ALU_FLAGS_EN
      check4({vecs[i].name, "_flags"}, flags, vecs[i].f);
`endif
    end

    // Mid-cycle input changes must not reach Z until the next edge.
    apply(32'd10, 32'd20, 4'd2);
    A = 32'd100; B = 32'd1; S = 4'd6;
    #3;
    check32("hold_between_edges", Z, 32'd30);
    @(posedge clk);
    #1;
    check32("capture_at_edge", Z, 32'd99);

    // Reset asserted mid-stream wins over the computed result.
    rst = 1'b1;
    apply(32'hFFFFFFFF, 32'h0, 4'd11);
    check32("reset_priority", Z, 32'h0);
    rst = 1'b0;

    for (int a = 0; a < 256; a += 5) begin
      for (int b = 0; b < 256; b += 3) begin
        for (int s = 0; s < 8; s++) begin
          apply(32'(a), 32'(b), 4'(s));
          check32($sformatf("sweep_a%0d_b%0d_s%0d", a, b, s), Z, ref_z(32'(a), 32'(b), 4'(s)));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
